// File: rtl/ex_hazard_controller.sv
// Hazard/forwarding controller for the 5-stage RV32 pipeline: operand forwarding
// selects, load-use stall, branch-redirect flush/squash, state tracking and event counters.
module ex_hazard_controller #(
    parameter int         CNT_W    = 32,
    parameter logic [1:0] LOAD_SRC = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RD_E,
    input  logic [1:0]       ResultSrcE,
    input  logic [4:0]       RD_M,
    input  logic             RegWriteM,
    input  logic [4:0]       RD_W,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             CntClr,
    output logic [1:0]       ForwardA_E,
    output logic [1:0]       ForwardB_E,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             SquashE,
    output logic [1:0]       HazState,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt,
    output logic [CNT_W-1:0] FwdCnt
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LDSTALL  = 2'b01,
        REDIRECT = 2'b10
    } haz_state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    haz_state_t       state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
    logic             lu, br, fwd_any;

    // M stage is younger than W, so its result wins; x0 is hard-wired zero.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rd_m, input logic we_m,
                                           input logic [4:0] rd_w, input logic we_w);
        if (we_m && rd_m != 5'd0 && rd_m == rs)
            return 2'b10;
        else if (we_w && rd_w != 5'd0 && rd_w == rs)
            return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        ForwardA_E = fwd_sel(Rs1E, RD_M, RegWriteM, RD_W, RegWriteW);
        ForwardB_E = fwd_sel(Rs2E, RD_M, RegWriteM, RD_W, RegWriteW);
        fwd_any    = (ForwardA_E != 2'b00) || (ForwardB_E != 2'b00);
        lu = (ResultSrcE == LOAD_SRC) && (RD_E != 5'd0) && ((RD_E == Rs1D) || (RD_E == Rs2D));
        br = PCSrcE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    always_comb begin
        state_d = RUN;
        if (br)
            state_d = REDIRECT;
        else if (lu)
            state_d = LDSTALL;
    end

    // A redirect makes everything in F/D/E wrong-path, so it overrides the load-use stall.
    always_comb begin
        StallF  = 1'b0;
        StallD  = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
        SquashE = 1'b0;
        if (br) begin
            FlushD  = 1'b1;
            FlushE  = 1'b1;
            SquashE = 1'b1;
        end else if (lu) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (CntClr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
            fwd_cnt_d   = '0;
        end else begin
            if (StallD && stall_cnt_q != CNT_MAX)
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            if (br && flush_cnt_q != CNT_MAX)
                flush_cnt_d = flush_cnt_q + CNT_ONE;
            if (fwd_any && fwd_cnt_q != CNT_MAX)
                fwd_cnt_d = fwd_cnt_q + CNT_ONE;
        end
    end

    assign HazState = state_q;
    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
    assign FwdCnt   = fwd_cnt_q;

endmodule
